dram_cmd_timer: RTL

Downstream command target of the DRAM controller: consumes the controller's `cmd_req`/`cmd` handshake and its one-hot bank/row/column selects, and returns `cmd_ack`. It tracks the open row of every bank and enforces fixed command latencies (tRCD, tCAS, tRP, tRFC). It flags protocol violations on `cmd_err`. It is the timing/bank-state model that closes the controller's request/acknowledge loop.

---
 rtl/dram_pkg.sv | 35 +++
 rtl/dram_onehot_enc.sv | 23 ++
 rtl/dram_cmd_timer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command timing model: command and state
// encodings plus default command latencies.
package dram_pkg;

  typedef enum logic [1:0] {
    CMD_REFRESH   = 2'b00,
    CMD_ACTIVATE  = 2'b01,
    CMD_READWRITE = 2'b10,
    CMD_PRECHARGE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_DRAIN
  } state_e;

  localparam int unsigned DEF_T_RCD = 3;
  localparam int unsigned DEF_T_CAS = 2;
  localparam int unsigned DEF_T_RP  = 3;
  localparam int unsigned DEF_T_RFC = 8;

  // Largest of four latencies; sizes the latency counter.
  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dram_onehot_enc.sv
// One-hot to binary index encoder. Zero or multi-hot input yields
// is_onehot = 0 and index = 0.
module dram_onehot_enc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             is_onehot
);

  // Exactly-one-bit test, then position of that bit.
  always_comb begin
    index     = '0;
    is_onehot = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);
    if (is_onehot) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (onehot[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dram_cmd_timer.sv
// DRAM command target: accepts one command per request/ack handshake,
// checks it against the per-bank open-row state, waits the command
// latency, acks (with error flag) and commits bank state on legal commands.
module dram_cmd_timer
  import dram_pkg::*;
#(
  parameter int unsigned NUM_OF_BANKS = 8,
  parameter int unsigned NUM_OF_ROWS  = 128,
  parameter int unsigned NUM_OF_COLS  = 8,
  parameter int unsigned T_RCD        = DEF_T_RCD,
  parameter int unsigned T_CAS        = DEF_T_CAS,
  parameter int unsigned T_RP         = DEF_T_RP,
  parameter int unsigned T_RFC        = DEF_T_RFC
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic                    bank_rw,
  output logic                    cmd_ack,
  output logic                    cmd_err,
  output logic [NUM_OF_BANKS-1:0] open_row_valid,
  output logic                    busy
);

  localparam int unsigned T_MAX  = max_of4(T_RCD, T_CAS, T_RP, T_RFC);
  localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;
  localparam int unsigned BANK_W = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int unsigned ROW_W  = (NUM_OF_ROWS > 1)  ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int unsigned COL_W  = (NUM_OF_COLS > 1)  ? $clog2(NUM_OF_COLS)  : 1;

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  logic [BANK_W-1:0]  bank_idx;
  logic [ROW_W-1:0]   row_idx;
  logic [COL_W-1:0]   col_idx;
  logic               bank_ok, row_ok, col_ok;

  cmd_e               cmd_in;
  logic               illegal_now;
  logic [CNT_W-1:0]   lat_now;
  logic               err_next;

  cmd_e               cmd_q;
  logic [BANK_W-1:0]  bank_idx_q;
  logic [ROW_W-1:0]   row_idx_q;
  logic [COL_W-1:0]   col_idx_q;
  logic               rw_q;
  logic               illegal_q;

  logic [ROW_W-1:0]   open_row [NUM_OF_BANKS];

  dram_onehot_enc #(.WIDTH(NUM_OF_BANKS)) u_bank_enc (
    .onehot    (bank_sel),
    .index     (bank_idx),
    .is_onehot (bank_ok)
  );

  dram_onehot_enc #(.WIDTH(NUM_OF_ROWS)) u_row_enc (
    .onehot    (row_sel),
    .index     (row_idx),
    .is_onehot (row_ok)
  );

  dram_onehot_enc #(.WIDTH(NUM_OF_COLS)) u_col_enc (
    .onehot    (col_sel),
    .index     (col_idx),
    .is_onehot (col_ok)
  );

  assign cmd_in = cmd_e'(cmd);

  // Legality of the presented command against current bank state, and its latency.
  always_comb begin
    illegal_now = 1'b0;
    if (cmd_in != CMD_REFRESH && !bank_ok) illegal_now = 1'b1;
    case (cmd_in)
      CMD_ACTIVATE:  if (!row_ok || open_row_valid[bank_idx])  illegal_now = 1'b1;
      CMD_READWRITE: if (!col_ok || !open_row_valid[bank_idx]) illegal_now = 1'b1;
      CMD_REFRESH:   if (|open_row_valid)                      illegal_now = 1'b1;
      default:       ;
    endcase

    lat_now = CNT_W'(1);
    if (!illegal_now) begin
      case (cmd_in)
        CMD_ACTIVATE:  lat_now = CNT_W'(T_RCD);
        CMD_READWRITE: lat_now = CNT_W'(T_CAS);
        CMD_PRECHARGE: lat_now = CNT_W'(T_RP);
        default:       lat_now = CNT_W'(T_RFC);
      endcase
    end
  end

  // Next-state logic. The counter holds the WAIT cycles still to run, so a
  // latency-1 command goes straight from IDLE to ACK with the ack landing
  // one cycle after acceptance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_req) begin
          cnt_next   = lat_now - CNT_W'(1);
          state_next = (lat_now == CNT_W'(1)) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = ST_ACK;
      end
      ST_ACK: begin
        cnt_next   = '0;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!cmd_req) state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase

    err_next = 1'b0;
    if (state_next == ST_ACK) err_next = (state == ST_IDLE) ? illegal_now : illegal_q;
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cmd_ack <= (state_next == ST_ACK);
      cmd_err <= err_next;
      busy    <= (state_next != ST_IDLE);
    end
  end

  // Capture the accepted command; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cmd_q      <= CMD_REFRESH;
      bank_idx_q <= '0;
      row_idx_q  <= '0;
      col_idx_q  <= '0;
      rw_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (state == ST_IDLE && cmd_req) begin
      cmd_q      <= cmd_in;
      bank_idx_q <= bank_idx;
      row_idx_q  <= row_idx;
      col_idx_q  <= col_idx;
      rw_q       <= bank_rw;
      illegal_q  <= illegal_now;
    end
  end

  // Bank state commit in the ACK cycle, legal commands only.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      open_row_valid <= '0;
      for (int unsigned b = 0; b < NUM_OF_BANKS; b++) open_row[b] <= '0;
    end else if (state == ST_ACK && !illegal_q) begin
      case (cmd_q)
        CMD_ACTIVATE: begin
          open_row_valid[bank_idx_q] <= 1'b1;
          open_row[bank_idx_q]       <= row_idx_q;
        end
        CMD_PRECHARGE: open_row_valid[bank_idx_q] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
